// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing helpers for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Counter width able to hold the longer of the two latencies.
    function automatic int MD_CNT_W(input int mult_cycles, input int div_cycles);
        int mx;
        mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return (mx < 2) ? 1 : $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/muldiv_arith.sv
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu on latched operands.
module muldiv_arith
    import muldiv_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        wr_en
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic [31:0] dvd;
    logic [31:0] dvs_mag;
    logic [31:0] dvs;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide works on magnitudes; 0x80000000 / -1 falls out as lo=0x80000000, hi=0.
    assign signed_div = (op == MD_DIV);
    assign dvd        = (signed_div && a[31]) ? -a : a;
    assign dvs_mag    = (signed_div && b[31]) ? -b : b;
    assign dvs        = (b == 32'd0) ? 32'd1 : dvs_mag;
    assign uq         = dvd / dvs;
    assign ur         = dvd % dvs;
    assign q          = (signed_div && (a[31] ^ b[31])) ? -uq : uq;
    assign r          = (signed_div && a[31]) ? -ur : ur;

    always_comb begin
        result = 64'd0;
        wr_en  = 1'b0;
        case (op)
            MD_MULT: begin
                result = prod_s;
                wr_en  = 1'b1;
            end
            MD_MULTU: begin
                result = prod_u;
                wr_en  = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                result = {r, q};
                wr_en  = (b != 32'd0);
            end
            default: begin
                result = 64'd0;
                wr_en  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_sched.sv
// HI/LO owner beside the E-stage ALU: fixed-latency mult/div sequencing and D-stage stall request.
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_uses_md,
    output logic        stall_req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = MD_CNT_W(MULT_CYCLES, DIV_CYCLES);

    logic [0:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       op_reg;
    logic [31:0]      a_reg;
    logic [31:0]      b_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic [63:0]      result;
    logic             wr_en;
    logic             start_busy_op;

    muldiv_arith u_arith (
        .op     (op_reg),
        .a      (a_reg),
        .b      (b_reg),
        .result (result),
        .wr_en  (wr_en)
    );

    // Also covers the issue cycle so an mfhi right behind a mult stalls immediately.
    assign start_busy_op = start & ~md_op[2];
    assign busy          = (state_reg == ST_RUN);
    assign stall_req     = d_uses_md & (busy | start_busy_op);
    assign hi            = hi_reg;
    assign lo            = lo_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= 3'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        case (md_op)
                            MD_MULT, MD_MULTU: begin
                                op_reg    <= md_op;
                                a_reg     <= a;
                                b_reg     <= b;
                                cnt_reg   <= CNT_W'(MULT_CYCLES);
                                state_reg <= ST_RUN;
                            end
                            MD_DIV, MD_DIVU: begin
                                op_reg    <= md_op;
                                a_reg     <= a;
                                b_reg     <= b;
                                cnt_reg   <= CNT_W'(DIV_CYCLES);
                                state_reg <= ST_RUN;
                            end
                            MD_MTHI: hi_reg <= a;
                            MD_MTLO: lo_reg <= a;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        if (wr_en) begin
                            hi_reg <= result[63:32];
                            lo_reg <= result[31:0];
                        end
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: scoreboarded HI/LO results, busy length and stall behaviour.
module tb_muldiv_sched;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_uses_md;
    logic        stall_req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;
    logic [63:0] exp_q[$];

    muldiv_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .a         (a),
        .b         (b),
        .d_uses_md (d_uses_md),
        .stall_req (stall_req),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hazard control must never issue while the unit is running.
    always @(posedge clk) begin
        if (!reset && start && busy) begin
            bad++;
            $error("FAIL issue_while_busy: start=%0b busy=%0b required no overlap", start, busy);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue a busy op, push the expected {hi,lo}, then measure busy length and pop/compare.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] va,
                          input logic [31:0] vb, input logic dum, input int n,
                          input logic [63:0] expect_hilo);
        int cyc;
        logic [63:0] e;
        @(negedge clk);
        start = 1'b1; md_op = op; a = va; b = vb; d_uses_md = dum;
        exp_q.push_back(expect_hilo);
        #1;
        chk({tag, "_stall_issue"}, {63'd0, stall_req}, {63'd0, dum});
        @(negedge clk);
        start = 1'b0; md_op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
        cyc = 0;
        while (busy === 1'b1 && cyc < 50) begin
            if (stall_req !== dum) begin
                chk({tag, "_stall_busy"}, {63'd0, stall_req}, {63'd0, dum});
            end
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'(n));
        chk({tag, "_stall_after"}, {63'd0, stall_req}, 64'd0);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
            chk({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
        end
        $display("txn %s op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", tag, op, va, vb, cyc, hi, lo);
        d_uses_md = 1'b0;
    endtask

    task automatic move_op(input string tag, input logic [2:0] op, input logic [31:0] va,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(negedge clk);
        start = 1'b1; md_op = op; a = va; b = 32'h0; d_uses_md = 1'b1;
        #1;
        chk({tag, "_stall"}, {63'd0, stall_req}, 64'd0);
        @(negedge clk);
        start = 1'b0; d_uses_md = 1'b0;
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
        $display("txn %s op=%0d a=%h hi=%h lo=%h", tag, op, va, hi, lo);
    endtask

    initial begin
        int quiet_bad;
        total = 0; bad = 0;
        reset = 1'b1; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0; d_uses_md = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        d_uses_md = 1'b1; #1;
        chk("rst_stall", {63'd0, stall_req}, 64'd0);
        d_uses_md = 1'b0;

        run_op("mult",  3'b000, 32'hFFFFFFFF, 32'd2, 1'b1, 5,  {32'hFFFFFFFF, 32'hFFFFFFFE});
        run_op("multu", 3'b001, 32'hFFFFFFFF, 32'd2, 1'b0, 5,  {32'h00000001, 32'hFFFFFFFE});
        run_op("div",   3'b010, 32'hFFFFFFF9, 32'd2, 1'b1, 10, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op("divu",  3'b011, 32'd7,        32'd2, 1'b0, 10, {32'h00000001, 32'h00000003});

        move_op("mthi", 3'b100, 32'h12345678, 32'h12345678, 32'h00000003);
        move_op("mtlo", 3'b101, 32'hCAFEBABE, 32'h12345678, 32'hCAFEBABE);

        run_op("div0",  3'b010, 32'd5,        32'd0,        1'b1, 10, {32'h12345678, 32'hCAFEBABE});
        run_op("divov", 3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, {32'h00000000, 32'h80000000});

        move_op("undef", 3'b111, 32'hDEADBEEF, 32'h00000000, 32'h80000000);

        run_op("mult34", 3'b000, 32'd3, 32'd4, 1'b0, 5, {32'h00000000, 32'h0000000C});
        move_op("mthi2", 3'b100, 32'h55AA55AA, 32'h55AA55AA, 32'h0000000C);

        // Abort a divide mid-run with reset.
        @(negedge clk);
        start = 1'b1; md_op = 3'b011; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        quiet_bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) quiet_bad++;
        end
        chk("abort_quiet", 64'(quiet_bad), 64'd0);
        $display("txn abort busy=%0b hi=%h lo=%h", busy, hi, lo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Multiply/divide sequencer for the five-stage MIPS pipeline: owns HI/LO, accepts mult/multu/div/divu/mthi/mtlo issued from E stage, models fixed multi-cycle latency with a busy counter and raises a stall request to hazard control whenever a D-stage instruction touches HI/LO while the unit is (or is about to be) busy. Sits beside the E-stage ALU; `hi`/`lo` feed the mfhi/mflo forwarding mux.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu (≥1)
- `DIV_CYCLES`, 10, busy cycles for div/divu (≥1)

- `clk` in 1 — single clock, all state on rising edge
- `reset` in 1 — synchronous, active-high
- `start` in 1 — E-stage issues an md op this cycle (pipeline not stalled)
- `md_op` in 3 — 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op
- `a` in 32 — rs value (forwarded)
- `b` in 32 — rt value (forwarded)
- `d_uses_md` in 1 — D-stage instr is mult/div/mfhi/mflo/mthi/mtlo
- `stall_req` out 1 — combinational: `d_uses_md & (busy | start_busy_op)`
- `busy` out 1 — registered, unit in RUN
- `hi` out 32 — HI register
- `lo` out 32 — LO register

## Operation
- States: IDLE, RUN. Counter `cnt` sized for max(MULT_CYCLES, DIV_CYCLES).
- IDLE + start + mult-class op: latch a, b, op; cnt←N (MULT_CYCLES or DIV_CYCLES); → RUN.
- IDLE + start + mthi/mtlo: write hi←a or lo←a at this edge; stay IDLE; busy stays 0.
- RUN: cnt decrements each edge; on edge where cnt==1 write hi/lo from latched operands, → IDLE.
- `start` while RUN: ignored (hazard control guarantees it cannot occur; assertion in bench).
- `start_busy_op` = start & md_op ∈ {000..011}.
- Arithmetic: mult signed 32×32→64, multu unsigned; {hi,lo} = product.
- div/divu: lo = quotient, hi = remainder; signed truncates toward zero, remainder takes sign of dividend.
- Overflow 0x80000000 / 0xFFFFFFFF (div): lo=0x80000000, hi=0.
- Divide by zero: full DIV_CYCLES busy, hi/lo unchanged.
- Undefined md_op with start: no-op, no state change.

## Timing
- Reset: hi=0, lo=0, busy=0, state IDLE, cnt=0; reset in RUN aborts, no HI/LO write.
- start sampled at edge T → busy=1 for cycles T+1..T+N; HI/LO new value and busy=0 from cycle T+N+1.
- mthi/mtlo at edge T → value visible cycle T+1.
- stall_req zero-latency (combinational) so the mfhi behind a mult stalls in the issue cycle itself.
- Result operands latched at start; later changes on a/b have no effect.

## Structure
- Package `muldiv_pkg`: md_op encodings, state enum, `MD_CNT_W` width function.
- Sub-module `muldiv_arith`: combinational 64-bit result from (op, a, b) incl. signed/zero/overflow rules; sequencer instantiates it on latched operands.

## Test plan
- mult a=0xFFFFFFFF b=2 → after 5 busy cycles hi=0xFFFFFFFF lo=0xFFFFFFFE; multu same → hi=1 lo=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9) b=2 → 10 busy cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF; divu 7/2 → lo=3 hi=1.
- mult issued with d_uses_md=1 → stall_req=1 in issue cycle and all 5 busy cycles, 0 in cycle T+6.
- mthi a=0x12345678 → hi updated next cycle, busy never asserted; div by zero → hi/lo unchanged, busy 10 cycles.
- reset asserted in cycle 3 of a div → busy=0, hi=lo=0 next cycle, no later write.
- div 0x80000000 / 0xFFFFFFFF → lo=0x80000000 hi=0.
